pipe_reg_chain: RTL and testbench

//  - Parametrised successor to the single-bit D flip-flop.
//  - DEPTH-stage, WIDTH-bit register pipeline with a valid/ready handshake on

---
 rtl/pipe_pkg.sv | 9 +
 rtl/pipe_reg_stage.sv | 69 ++++++
 rtl/pipe_reg_chain.sv | 104 ++++++++++
 tb/tb_pipe_reg_chain.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared helpers for the register-pipeline slice.
// occ_w gives the width needed to count 0..depth valid stages.
package pipe_pkg;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One valid/ready register stage: a valid bit plus a payload register.
// It loads whenever it is empty or its downstream neighbour is ready this cycle.
module pipe_reg_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RESET_DATA = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  input  logic             rdy_in,
  output logic             rdy_out,
  output logic             out_v,
  output logic [WIDTH-1:0] out_d
);

  logic             vld_q;
  logic             vld_d;
  logic [WIDTH-1:0] dat_q;
  logic [WIDTH-1:0] dat_d;

  // An empty stage can always take a beat, which is what collapses bubbles.
  assign rdy_out = !vld_q || rdy_in;
  assign out_v   = vld_q;
  assign out_d   = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = 1'b0;
      if (RESET_DATA != 0) begin
        dat_d = '0;
      end
    end else if (rdy_out) begin
      vld_d = in_v;
      if (in_v) begin
        dat_d = in_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Leaving the payload unreset lets synthesis use cheaper flops when allowed.
  if (RESET_DATA != 0) begin : g_dat_rst
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dat_q <= '0;
      end else begin
        dat_q <= dat_d;
      end
    end
  end else begin : g_dat_norst
    always_ff @(posedge clk) begin
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage, WIDTH-bit valid/ready register pipeline with bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 3,
  parameter int RESET_DATA = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH-1:0]          m_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_reg_chain: WIDTH must be at least 1");
  end

  logic             vld [DEPTH];
  logic [WIDTH-1:0] dat [DEPTH];
  logic             rdy [DEPTH];
  logic             s_xfer;
  logic             m_xfer;

  // Reset and flush both block new input so nothing slips in during clearing.
  assign s_ready = rst_n && !flush && rdy[0];
  assign s_xfer  = s_valid && s_ready;
  assign m_valid = vld[DEPTH-1];
  assign m_data  = dat[DEPTH-1];
  assign m_xfer  = m_valid && m_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             stage_in_v;
    logic [WIDTH-1:0] stage_in_d;
    logic             stage_rdy_in;

    if (i == 0) begin : g_head
      assign stage_in_v = s_xfer;
      assign stage_in_d = s_data;
    end else begin : g_body
      assign stage_in_v = vld[i-1];
      assign stage_in_d = dat[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign stage_rdy_in = m_ready;
    end else begin : g_mid
      assign stage_rdy_in = rdy[i+1];
    end

    pipe_reg_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .in_v    (stage_in_v),
      .in_d    (stage_in_d),
      .rdy_in  (stage_rdy_in),
      .rdy_out (rdy[i]),
      .out_v   (vld[i]),
      .out_d   (dat[i])
    );
  end

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Tracks popcount of the valid bits incrementally from the two transfers.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (s_xfer && !m_xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!s_xfer && m_xfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=8, DEPTH=3): vector tables plus a
// scoreboarded streaming sequence.
module tb_pipe_reg_chain;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occupancy;

  int total_checks;
  int passed_checks;

  pipe_reg_chain #(
    .WIDTH      (8),
    .DEPTH      (3),
    .RESET_DATA (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       flush;
    logic       s_valid;
    logic [7:0] s_data;
    logic       m_ready;
    logic       exp_s_ready;
    logic       exp_m_valid;
    logic [7:0] exp_m_data;
    int         exp_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input string name, input logic r, input logic f,
                                  input logic sv, input logic [7:0] sd, input logic mr,
                                  input logic esr, input logic emv, input logic [7:0] emd,
                                  input int eocc);
    vec_t v;
    v.name = name; v.rst_n = r; v.flush = f; v.s_valid = sv; v.s_data = sd;
    v.m_ready = mr; v.exp_s_ready = esr; v.exp_m_valid = emv; v.exp_m_data = emd;
    v.exp_occ = eocc;
    vecs.push_back(v);
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    total_checks++;
    if (actual == expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic f, input logic sv,
                                input logic [7:0] sd, input logic mr);
    rst_n   = r;
    flush   = f;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
  endtask

  // Inputs change at negedge; outputs are sampled 1ns later, then one clock passes.
  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].flush, vecs[i].s_valid, vecs[i].s_data,
                     vecs[i].m_ready);
      #1;
      check_output({vecs[i].name, ".s_ready"}, int'(s_ready), int'(vecs[i].exp_s_ready));
      check_output({vecs[i].name, ".m_valid"}, int'(m_valid), int'(vecs[i].exp_m_valid));
      check_output({vecs[i].name, ".occ"}, int'(occupancy), vecs[i].exp_occ);
      if (vecs[i].exp_m_valid) begin
        check_output({vecs[i].name, ".m_data"}, int'(m_data), int'(vecs[i].exp_m_data));
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_streaming();
    logic [7:0] exp_q[$];
    int sent;
    int received;
    bit started;
    sent = 0;
    received = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < 40 && (sent < 16 || exp_q.size() > 0); cyc++) begin
      if (sent < 16) begin
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'(sent + 1), 1'b1);
      end else begin
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      end
      #1;
      if (sent < 16) begin
        check_output("stream.s_ready", int'(s_ready), 1);
      end
      if (started && exp_q.size() > 0) begin
        check_output("stream.m_valid_gapless", int'(m_valid), 1);
      end
      if (m_valid) begin
        started = 1'b1;
        if (exp_q.size() > 0) begin
          check_output("stream.m_data", int'(m_data), int'(exp_q.pop_front()));
        end else begin
          check_output("stream.unexpected_beat", int'(m_data), -1);
        end
        received++;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check_output("stream.received", received, 16);
    check_output("stream.leftover", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total_checks  = 0;
    passed_checks = 0;

    // Reset held with s_valid=1, then a single-beat latency probe.
    add_vec("rst0",  1'b0, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    add_vec("rst1",  1'b0, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    add_vec("rel",   1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    add_vec("lat_t", 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    add_vec("lat_1", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1);
    add_vec("lat_2", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1);
    add_vec("lat_3", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1);
    add_vec("lat_4", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    // Stall with a bubble, fill, then a simultaneous accept and emit while full.
    add_vec("st_11", 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 0);
    add_vec("st_id", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1);
    add_vec("st_22", 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1);
    add_vec("st_33", 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 2);
    add_vec("full",  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 3);
    add_vec("fsim",  1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h11, 3);
    add_vec("dr_22", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3);
    add_vec("dr_33", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2);
    add_vec("dr_44", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1);
    add_vec("dr_mt", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    // Flush at occupancy 2 while a beat is offered.
    add_vec("fl_55", 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 0);
    add_vec("fl_66", 1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 8'h00, 1);
    add_vec("flush", 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 2);
    add_vec("fl_p0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    add_vec("fl_p1", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    add_vec("fl_p2", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    add_vec("fl_p3", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    // Reset in the middle of a stream discards everything in flight.
    add_vec("mr_88", 1'b1, 1'b0, 1'b1, 8'h88, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    add_vec("mr_89", 1'b1, 1'b0, 1'b1, 8'h89, 1'b1, 1'b1, 1'b0, 8'h00, 1);
    add_vec("mr_rst",1'b0, 1'b0, 1'b1, 8'h8A, 1'b1, 1'b0, 1'b0, 8'h00, 2);
    add_vec("mr_p0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    add_vec("mr_p1", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    add_vec("mr_p2", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    add_vec("mr_p3", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0);

    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
    @(posedge clk);
    @(negedge clk);

    run_vectors(0, 7);
    run_streaming();
    run_vectors(8, vecs.size() - 1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
